fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end that replaces the single fixed fetch register of the multicycle core.
- Issues pipelined requests to the synchronous instruction memory, which has 1-cycle read latency.
- Buffers returned words with their PCs in a DEPTH-entry prefetch queue and presents them to the control/decode side with a valid/ready handshake.
- Supports pipeline redirects (branch/jump) with flush of queued and in-flight fetches.

Parameters:
- XLEN, 32, width of addresses and instruction words.
- DEPTH, 4, prefetch queue entries; power of two, ≥2.
- RESET_PC, 32'h1000, first fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  synchronous, active-high reset.
- fetch_en  input  1  permits new memory requests; when low, queue still drains and responses still land.
- imem_req  output  1  request issued this cycle (combinational).
- imem_address  output  XLEN  fetch address, equal to the internal fetch_pc.
- imem_data_out  input  XLEN  memory read data, valid the cycle after the request.
- instr_valid  output  1  queue head holds a valid instruction.
- instr_ready  input  1  consumer takes the head this cycle.
- instr  output  XLEN  head instruction word.
- instr_pc  output  XLEN  PC of the head instruction.
- redirect  input  1  flush and restart fetch.
- redirect_pc  input  XLEN  new fetch address.
- align_err  output  1  one-cycle pulse, the cycle after a redirect with redirect_pc[1:0] != 0.
- occupancy  output  $clog2(DEPTH)+1  current queue entry count.

Behaviour:
- Reset (sync, high):
  - fetch_pc <= RESET_PC; head/tail pointers, count and inflight_q <= 0.
  - align_err <= 0; instr_valid = 0; occupancy = 0.
  - imem_req is 0 while reset is high.
- Request rule: imem_req = fetch_en & ~redirect & ~reset & (count + inflight_q < DEPTH).
  - This credit check is conservative: a same-cycle pop is not credited.
- On imem_req:
  - fetch_pc <= fetch_pc + PC_STEP (mod 2^XLEN; wraps silently).
  - inflight_q <= 1 and req_pc_q <= fetch_pc.
  - Otherwise inflight_q <= 0.
- Response: when inflight_q=1 and redirect=0, push {imem_data_out, req_pc_q} at the tail at the clock edge.
- Pop: when instr_valid & instr_ready & ~redirect, advance head.
  - Push and pop in the same cycle leave count unchanged.
- Head outputs are combinational reads of the head entry.
  - instr and instr_pc are don't-care when instr_valid=0; the bench must not check them then.
- Latency: first instr_valid goes high 2 cycles after the first edge with reset low.
  - Sustained throughput is 1 instruction/cycle while instr_ready is held high.
- Redirect (highest priority over push, pop and request):
  - count, head and tail <= 0; the response arriving in the redirect cycle is dropped.
  - No request is issued in the redirect cycle; inflight_q <= 0.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; align_err <= |redirect_pc[1:0].
  - The first post-redirect request is issued the next cycle. instr_valid returns 2 cycles after that request.
- Full: count + inflight_q = DEPTH blocks requests; overflow is impossible by construction.
  - An assertion must check that a push never occurs when count = DEPTH.
- Empty: instr_valid = 0; instr_ready is ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally; count is $clog2(DEPTH)+1 bits.
- fetch_en low mid-stream: the outstanding response still lands; no further requests are issued.
- Reset mid-operation: all state clears on the edge, identical to power-up reset.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t {instr, pc}, parametrised by XLEN through a package localparam defaulting to 32.
  - Constant NOP_INSTR = 32'h0000_0013, used as the instr value when the queue is empty.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, DEPTH entries.
  - Inputs push, pop, flush; outputs head, count.
  - Reused later by the data-side store buffer.
- fetch_unit holds fetch_pc, inflight_q/req_pc_q, request credit logic and redirect/align handling.

Test Plan:
- Reset release, memory model returning data = address, instr_ready=1:
  - imem_address sequence 0x1000, 0x1004, 0x1008.
  - instr_valid first high 2 cycles after release, with instr=instr_pc=0x1000, then 0x1004 on consecutive cycles.
- instr_ready=0, DEPTH=4:
  - Exactly 4 requests (0x1000–0x100C) issued; imem_req stays 0; occupancy=4.
  - Raising instr_ready for 1 cycle pops 0x1000; one new request to 0x1010 follows.
- Redirect to 0x2000 while occupancy=3 and a response is in flight:
  - Next cycle occupancy=0, instr_valid=0, imem_address=0x2000.
  - The next valid instr_pc is 0x2000; none of 0x1000-series appears afterwards.
- redirect_pc=0x2002:
  - align_err pulses for exactly 1 cycle; fetch resumes at 0x2000.
- fetch_en dropped for 3 cycles mid-stream:
  - The in-flight word is still delivered; no requests during the gap.
  - PCs resume contiguously with no skipped or duplicated instr_pc.
- Wrap-around, RESET_PC=32'hFFFF_FFF8:
  - Fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order.
  - Queue pointers wrap over more than 3×DEPTH pops with data intact.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: queue entry layout and the
// filler word presented when no instruction is available.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch_entry_t with flush; head is a combinational read.
// Callers gate push/pop against full/empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [AW:0]  count
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    fetch_entry_t   entries [DEPTH];
    logic [AW-1:0]  head_q;
    logic [AW-1:0]  tail_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[tail_q] <= din;
                tail_q          <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = entries[head_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && count == FULL));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: pipelined requests to a 1-cycle synchronous
// memory, DEPTH-entry prefetch queue, valid/ready delivery and redirect flush.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h1000,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_address,
    input  logic [XLEN-1:0]          imem_data_out,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [XLEN-1:0]          instr,
    output logic [XLEN-1:0]          instr_pc,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     align_err,
    output logic [$clog2(DEPTH):0]   occupancy
);
    import fetch_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc_q;
    logic            inflight_q;
    logic [AW:0]     count;
    logic            credit;
    logic            push;
    logic            pop;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    // Slots already promised to an in-flight response count as used; a pop in
    // the same cycle is deliberately not credited.
    assign credit   = ({1'b0, count} + (AW + 2)'(inflight_q)) < (AW + 2)'(DEPTH);
    assign imem_req = fetch_en & ~redirect & ~reset & credit;

    assign push        = inflight_q & ~redirect;
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign push_entry  = '{instr: imem_data_out, pc: req_pc_q};

    assign imem_address = fetch_pc;
    assign instr_valid  = (count != '0);
    assign instr        = instr_valid ? head.instr : NOP_INSTR;
    assign instr_pc     = head.pc;
    assign occupancy    = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            align_err  <= 1'b0;
        end else if (redirect) begin
            fetch_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight_q <= 1'b0;
            align_err  <= |redirect_pc[1:0];
        end else begin
            align_err  <= 1'b0;
            inflight_q <= imem_req;
            if (imem_req) begin
                fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                req_pc_q <= fetch_pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .head  (head),
        .count (count)
    );

endmodule
